// File: rtl/uart_cmd_ctrl.sv
// Command sequencer: decodes byte-framed commands from the UART RX path, drives register-file
// writes/reads and ALU operations, then queues response bytes into the TX FIFO.
module uart_cmd_ctrl #(
  parameter int unsigned    DW          = 8,
  parameter int unsigned    AW          = 4,
  parameter int unsigned    TIMEOUT     = 255,
  parameter logic [DW-1:0]  CMD_WR      = 8'hAA,
  parameter logic [DW-1:0]  CMD_RD      = 8'hBB,
  parameter logic [DW-1:0]  CMD_ALU_OP  = 8'hCC,
  parameter logic [DW-1:0]  CMD_ALU_NOP = 8'hDD
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [DW-1:0]   RX_P_DATA,
  input  logic            RX_D_VLD,
  input  logic [DW-1:0]   RdData,
  input  logic            RdData_Valid,
  input  logic [2*DW-1:0] ALU_OUT,
  input  logic            ALU_OUT_VLD,
  input  logic            FIFO_FULL,
  output logic [AW-1:0]   Address,
  output logic            WrEn,
  output logic            RdEn,
  output logic [DW-1:0]   WrData,
  output logic            ALU_EN,
  output logic [3:0]      ALU_FUN,
  output logic            CLK_EN,
  output logic [DW-1:0]   TX_P_DATA,
  output logic            WR_INC,
  output logic            cmd_err
);

  // Wide enough to hold TIMEOUT-1.
  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [3:0] {
    StIdle, StWrAddr, StWrData, StRdAddr, StRdWait,
    StAluA, StAluB, StAluFn, StAluWait, StTxSend
  } state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [2*DW-1:0]   result_q, result_d;
  logic              byte_idx_q, byte_idx_d;
  logic [1:0]        tx_len_q, tx_len_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic cmd_known;
  logic timed_out;

  assign cmd_known = (RX_P_DATA == CMD_WR) || (RX_P_DATA == CMD_RD) ||
                     (RX_P_DATA == CMD_ALU_OP) || (RX_P_DATA == CMD_ALU_NOP);
  assign timed_out = (cnt_q == CW'(TIMEOUT - 1));

  // Next-state, operand capture and timeout counting.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    result_d   = result_q;
    byte_idx_d = byte_idx_q;
    tx_len_d   = tx_len_q;
    cnt_d      = cnt_q;
    case (state_q)
      StIdle: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == CMD_WR)           state_d = StWrAddr;
          else if (RX_P_DATA == CMD_RD)      state_d = StRdAddr;
          else if (RX_P_DATA == CMD_ALU_OP)  state_d = StAluA;
          else if (RX_P_DATA == CMD_ALU_NOP) state_d = StAluFn;
        end
      end
      StWrAddr: if (RX_D_VLD) begin
        addr_d  = RX_P_DATA[AW-1:0];
        state_d = StWrData;
      end
      StWrData: if (RX_D_VLD) state_d = StIdle;
      StRdAddr: if (RX_D_VLD) begin
        cnt_d   = '0;
        state_d = StRdWait;
      end
      StRdWait: begin
        // A valid strobe on the timeout cycle takes priority over the error.
        if (RdData_Valid) begin
          result_d[DW-1:0] = RdData;
          tx_len_d         = 2'd1;
          byte_idx_d       = 1'b0;
          state_d          = StTxSend;
        end else if (timed_out) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StAluA: if (RX_D_VLD) state_d = StAluB;
      StAluB: if (RX_D_VLD) state_d = StAluFn;
      StAluFn: if (RX_D_VLD) begin
        cnt_d   = '0;
        state_d = StAluWait;
      end
      StAluWait: begin
        if (ALU_OUT_VLD) begin
          result_d   = ALU_OUT;
          tx_len_d   = 2'd2;
          byte_idx_d = 1'b0;
          state_d    = StTxSend;
        end else if (timed_out) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StTxSend: begin
        if (!FIFO_FULL) begin
          byte_idx_d = ~byte_idx_q;
          if ({1'b0, byte_idx_q} == tx_len_q - 2'd1) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Mealy output decode; gated by RST so every strobe drops as soon as reset asserts.
  always_comb begin
    Address   = '0;
    WrEn      = 1'b0;
    RdEn      = 1'b0;
    WrData    = '0;
    ALU_EN    = 1'b0;
    ALU_FUN   = '0;
    CLK_EN    = 1'b0;
    TX_P_DATA = '0;
    WR_INC    = 1'b0;
    cmd_err   = 1'b0;
    if (RST) begin
      case (state_q)
        StIdle:   cmd_err = RX_D_VLD && !cmd_known;
        StWrData: if (RX_D_VLD) begin
          WrEn    = 1'b1;
          Address = addr_q;
          WrData  = RX_P_DATA;
        end
        StRdAddr: if (RX_D_VLD) begin
          RdEn    = 1'b1;
          Address = RX_P_DATA[AW-1:0];
        end
        StRdWait: cmd_err = !RdData_Valid && timed_out;
        StAluA: if (RX_D_VLD) begin
          WrEn    = 1'b1;
          Address = AW'(0);
          WrData  = RX_P_DATA;
        end
        StAluB: if (RX_D_VLD) begin
          WrEn    = 1'b1;
          Address = AW'(1);
          WrData  = RX_P_DATA;
        end
        StAluFn: begin
          CLK_EN = 1'b1;
          if (RX_D_VLD) begin
            ALU_EN  = 1'b1;
            ALU_FUN = RX_P_DATA[3:0];
          end
        end
        StAluWait: begin
          CLK_EN  = 1'b1;
          cmd_err = !ALU_OUT_VLD && timed_out;
        end
        StTxSend: begin
          TX_P_DATA = byte_idx_q ? result_q[2*DW-1:DW] : result_q[DW-1:0];
          WR_INC    = !FIFO_FULL;
        end
        default: ;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      result_q   <= '0;
      byte_idx_q <= 1'b0;
      tx_len_q   <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      result_q   <= result_d;
      byte_idx_q <= byte_idx_d;
      tx_len_q   <= tx_len_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: randomized commands against an event-level model.
module tb_uart_cmd_ctrl;

  localparam int TO = 255;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  RX_P_DATA;
  logic        RX_D_VLD;
  logic [7:0]  RdData;
  logic        RdData_Valid;
  logic [15:0] ALU_OUT;
  logic        ALU_OUT_VLD;
  logic        FIFO_FULL;
  logic [3:0]  Address;
  logic        WrEn, RdEn, ALU_EN, CLK_EN, WR_INC, cmd_err;
  logic [7:0]  WrData, TX_P_DATA;
  logic [3:0]  ALU_FUN;
  logic [29:0] outs;

  int checks = 0;
  int errors = 0;

  // Observed and expected strobe events, one word each.
  logic [31:0] log_q[$];
  logic [31:0] exp_q[$];

  assign outs = {Address, WrEn, RdEn, WrData, ALU_EN, ALU_FUN, CLK_EN, TX_P_DATA, WR_INC, cmd_err};

  always #5 CLK = ~CLK;

  uart_cmd_ctrl dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RdData(RdData), .RdData_Valid(RdData_Valid), .ALU_OUT(ALU_OUT),
    .ALU_OUT_VLD(ALU_OUT_VLD), .FIFO_FULL(FIFO_FULL), .Address(Address), .WrEn(WrEn),
    .RdEn(RdEn), .WrData(WrData), .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .CLK_EN(CLK_EN),
    .TX_P_DATA(TX_P_DATA), .WR_INC(WR_INC), .cmd_err(cmd_err)
  );

  // Event kinds: 1 reg write, 2 reg read, 3 ALU start, 4 TX push, 5 error.
  function automatic logic [31:0] mk(input int t, input logic f, input logic [3:0] a,
                                     input logic [7:0] d);
    logic [7:0] tt;
    tt = t[7:0];
    return {tt, 7'b0, f, 4'b0, a, d};
  endfunction

  // Record every strobe; the flag shows whether an RX byte was present in that cycle.
  always @(negedge CLK) begin
    if (RST) begin
      if (WrEn)    log_q.push_back(mk(1, RX_D_VLD, Address, WrData));
      if (RdEn)    log_q.push_back(mk(2, RX_D_VLD, Address, 8'h00));
      if (ALU_EN)  log_q.push_back(mk(3, RX_D_VLD, 4'h0, {4'h0, ALU_FUN}));
      if (WR_INC)  log_q.push_back(mk(4, 1'b0, 4'h0, TX_P_DATA));
      if (cmd_err) log_q.push_back(mk(5, 1'b0, 4'h0, 8'h00));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not end, got time %0t required < 1000000", $time);
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // One RX_D_VLD pulse spanning exactly one rising edge.
  task automatic send(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    @(posedge CLK);
    #1;
    RX_D_VLD  = 1'b0;
    RX_P_DATA = 8'($urandom);
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if (outs !== 30'h0) begin
      errors++;
      $display("FAIL reset_outs_during: got %h required 0", outs);
    end
    RX_D_VLD = 1'b0;
    #20 RST = 1'b1;
    @(posedge CLK);
    #1;
    checks++;
    if (outs !== 30'h0) begin
      errors++;
      $display("FAIL reset_outs_after: got %h required 0", outs);
    end
  endtask

  task automatic test_write;
    logic [7:0] a, d;
    for (int r = 0; r < 4; r++) begin
      a = 8'($urandom);
      d = 8'($urandom);
      if (r == 0) begin
        a = 8'h05;
        d = 8'h3C;
      end
      log_q.delete();
      exp_q.delete();
      exp_q.push_back(mk(1, 1'b1, a[3:0], d));
      send(8'hAA); idle($urandom_range(0, 2));
      send(a);     idle($urandom_range(0, 2));
      send(d);     idle(3);
      checks++;
      if (log_q.size() != exp_q.size()) begin
        errors++;
        $display("FAIL write_events: got %0d events required %0d", log_q.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
        checks++;
        if (log_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL write_event%0d: got %h required %h", i, log_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_read;
    logic [7:0] a, d;
    int dly;
    for (int r = 0; r < 4; r++) begin
      a   = 8'($urandom);
      d   = 8'($urandom);
      dly = $urandom_range(0, 6);
      if (r == 0) begin
        a   = 8'h05;
        d   = 8'h3C;
        dly = 2;
      end
      log_q.delete();
      exp_q.delete();
      exp_q.push_back(mk(2, 1'b1, a[3:0], 8'h00));
      exp_q.push_back(mk(4, 1'b0, 4'h0, d));
      send(8'hBB); idle($urandom_range(0, 2));
      send(a);     idle(dly);
      RdData       = d;
      RdData_Valid = 1'b1;
      @(posedge CLK);
      #1;
      RdData_Valid = 1'b0;
      RdData       = 8'($urandom);
      #2;
      checks++;
      if (WR_INC !== 1'b1 || TX_P_DATA !== d) begin
        errors++;
        $display("FAIL read_push_cycle: got WR_INC=%b data=%h required 1 %h", WR_INC,
                 TX_P_DATA, d);
      end
      idle(3);
      checks++;
      if (log_q.size() != exp_q.size()) begin
        errors++;
        $display("FAIL read_events: got %0d events required %0d", log_q.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
        checks++;
        if (log_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL read_event%0d: got %h required %h", i, log_q[i], exp_q[i]);
        end
      end
    end
  endtask

  // Covers both operand and no-operand ALU commands, optionally with a full TX FIFO.
  task automatic test_alu(input int rounds, input bit with_full);
    logic [7:0]  a, b;
    logic [3:0]  fun;
    logic [15:0] res;
    int dly, hold;
    bit op;
    for (int r = 0; r < rounds; r++) begin
      a    = 8'($urandom);
      b    = 8'($urandom);
      fun  = 4'($urandom);
      res  = 16'($urandom);
      dly  = $urandom_range(0, 5);
      hold = $urandom_range(1, 6);
      op   = with_full || (r % 2 == 0);
      if (r == 0) begin
        a    = 8'h0A;
        b    = 8'h03;
        fun  = 4'h2;
        res  = 16'h001E;
        dly  = 1;
        hold = 4;
      end
      log_q.delete();
      exp_q.delete();
      if (op) begin
        exp_q.push_back(mk(1, 1'b1, 4'h0, a));
        exp_q.push_back(mk(1, 1'b1, 4'h1, b));
      end
      exp_q.push_back(mk(3, 1'b1, 4'h0, {4'h0, fun}));
      exp_q.push_back(mk(4, 1'b0, 4'h0, res[7:0]));
      exp_q.push_back(mk(4, 1'b0, 4'h0, res[15:8]));
      #2;
      checks++;
      if (CLK_EN !== 1'b0) begin
        errors++;
        $display("FAIL alu_clk_en_idle: got %b required 0", CLK_EN);
      end
      if (op) begin
        send(8'hCC); idle($urandom_range(0, 2));
        send(a);     idle($urandom_range(0, 2));
        send(b);
      end else begin
        send(8'hDD);
      end
      idle($urandom_range(0, 2));
      #2;
      checks++;
      if (CLK_EN !== 1'b1) begin
        errors++;
        $display("FAIL alu_clk_en_fn: got %b required 1", CLK_EN);
      end
      send({4'($urandom), fun});
      idle(dly);
      #2;
      checks++;
      if (CLK_EN !== 1'b1) begin
        errors++;
        $display("FAIL alu_clk_en_wait: got %b required 1", CLK_EN);
      end
      FIFO_FULL   = with_full;
      ALU_OUT     = res;
      ALU_OUT_VLD = 1'b1;
      @(posedge CLK);
      #1;
      ALU_OUT_VLD = 1'b0;
      ALU_OUT     = 16'($urandom);
      if (with_full) begin
        for (int k = 0; k < hold; k++) begin
          #2;
          checks++;
          if (WR_INC !== 1'b0 || TX_P_DATA !== res[7:0]) begin
            errors++;
            $display("FAIL full_stall%0d: got WR_INC=%b data=%h required 0 %h", k, WR_INC,
                     TX_P_DATA, res[7:0]);
          end
          @(posedge CLK);
          #1;
        end
        FIFO_FULL = 1'b0;
      end else begin
        #2;
        checks++;
        if (WR_INC !== 1'b1 || TX_P_DATA !== res[7:0] || CLK_EN !== 1'b0) begin
          errors++;
          $display("FAIL alu_first_push: got %b %h %b required 1 %h 0", WR_INC, TX_P_DATA,
                   CLK_EN, res[7:0]);
        end
      end
      idle(4);
      checks++;
      if (log_q.size() != exp_q.size()) begin
        errors++;
        $display("FAIL alu_events: got %0d events required %0d", log_q.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
        checks++;
        if (log_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL alu_event%0d: got %h required %h", i, log_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_bad_cmd;
    logic [7:0] c;
    for (int r = 0; r < 3; r++) begin
      do c = 8'($urandom); while (c inside {8'hAA, 8'hBB, 8'hCC, 8'hDD});
      if (r == 0) c = 8'h55;
      log_q.delete();
      exp_q.delete();
      exp_q.push_back(mk(5, 1'b0, 4'h0, 8'h00));
      send(c);
      idle(2);
      checks++;
      if (log_q.size() != exp_q.size() || log_q[0] !== exp_q[0]) begin
        errors++;
        $display("FAIL bad_cmd_%h: got %0d events required one error pulse", c, log_q.size());
      end
    end
  endtask

  task automatic test_timeout;
    logic [7:0] a, d;
    int hit;
    a   = 8'($urandom);
    d   = 8'($urandom);
    hit = 0;
    log_q.delete();
    exp_q.delete();
    exp_q.push_back(mk(2, 1'b1, a[3:0], 8'h00));
    exp_q.push_back(mk(5, 1'b0, 4'h0, 8'h00));
    exp_q.push_back(mk(1, 1'b1, 4'h1, d));
    send(8'hBB);
    send(a);
    // Cycle k counts from 1 in the first waiting cycle; a stray byte mid-wait must be ignored.
    for (int k = 1; k <= TO + 5; k++) begin
      @(negedge CLK);
      if (cmd_err === 1'b1) begin
        hit = k;
        break;
      end
      @(posedge CLK);
      #1;
      RX_D_VLD = (k == 9);
      RX_P_DATA = 8'h55;
    end
    RX_D_VLD = 1'b0;
    checks++;
    if (hit != TO) begin
      errors++;
      $display("FAIL timeout_cycle: got %0d required %0d", hit, TO);
    end
    idle(2);
    send(8'hAA);
    send(8'h01);
    send(d);
    idle(2);
    checks++;
    if (log_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL timeout_events: got %0d events required %0d", log_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (log_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL timeout_event%0d: got %h required %h", i, log_q[i], exp_q[i]);
      end
    end
  endtask

  // Valid strobe on the very cycle the timeout would fire.
  task automatic test_timeout_race;
    logic [7:0] a, d;
    a = 8'($urandom);
    d = 8'($urandom);
    log_q.delete();
    exp_q.delete();
    exp_q.push_back(mk(2, 1'b1, a[3:0], 8'h00));
    exp_q.push_back(mk(4, 1'b0, 4'h0, d));
    send(8'hBB);
    send(a);
    idle(TO - 1);
    RdData       = d;
    RdData_Valid = 1'b1;
    #2;
    checks++;
    if (cmd_err !== 1'b0) begin
      errors++;
      $display("FAIL race_no_err: got %b required 0", cmd_err);
    end
    @(posedge CLK);
    #1;
    RdData_Valid = 1'b0;
    idle(3);
    checks++;
    if (log_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL race_events: got %0d events required %0d", log_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (log_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL race_event%0d: got %h required %h", i, log_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] a, d, rd;
    a  = 8'($urandom);
    d  = 8'($urandom);
    rd = 8'($urandom);
    log_q.delete();
    exp_q.delete();
    exp_q.push_back(mk(1, 1'b1, a[3:0], d));
    exp_q.push_back(mk(2, 1'b1, a[3:0], 8'h00));
    exp_q.push_back(mk(4, 1'b0, 4'h0, rd));
    send(8'hAA); send(a); send(d); send(8'hBB); send(a);
    RdData       = rd;
    RdData_Valid = 1'b1;
    @(posedge CLK);
    #1;
    RdData_Valid = 1'b0;
    idle(3);
    checks++;
    if (log_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL b2b_events: got %0d events required %0d", log_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (log_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_event%0d: got %h required %h", i, log_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    send(8'hCC);
    send(8'h0A);
    RX_P_DATA = 8'h03;
    RX_D_VLD  = 1'b1;
    #2;
    checks++;
    if (WrEn !== 1'b1 || Address !== 4'h1) begin
      errors++;
      $display("FAIL mid_pre_reset: got WrEn=%b Address=%h required 1 1", WrEn, Address);
    end
    RST = 1'b0;
    #1;
    checks++;
    if (outs !== 30'h0) begin
      errors++;
      $display("FAIL mid_reset_outs: got %h required 0", outs);
    end
    @(posedge CLK);
    #1;
    RX_D_VLD = 1'b0;
    RST      = 1'b1;
    log_q.delete();
    exp_q.delete();
    exp_q.push_back(mk(1, 1'b1, 4'h1, 8'hFF));
    send(8'hAA);
    send(8'h01);
    send(8'hFF);
    idle(2);
    checks++;
    if (log_q.size() != exp_q.size() || log_q[0] !== exp_q[0]) begin
      errors++;
      $display("FAIL mid_reset_recover: got %0d events required one write to 1 of FF",
               log_q.size());
    end
  endtask

  initial begin
    RST          = 1'b0;
    RX_P_DATA    = 8'h55;
    RX_D_VLD     = 1'b1;
    RdData       = '0;
    RdData_Valid = 1'b0;
    ALU_OUT      = '0;
    ALU_OUT_VLD  = 1'b0;
    FIFO_FULL    = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_alu(4, 1'b0);
    test_alu(2, 1'b1);
    test_bad_cmd();
    test_timeout();
    test_timeout_race();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
